// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
// Holds the supervisor state encoding and the status counter widths.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAILED
  } pll_state_e;

  localparam int LOSS_W  = 8;
  localparam int RETRY_W = 4;

  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// The chain clears to 0 on reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL RESET pin, qualifies LOCK, and issues the downstream system reset.
// Runs on the PLL reference clock so it survives an invalid PLL output.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_reset_o,
  output logic               sys_rst_n_o,
  output logic               locked_o,
  output logic               fail_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [LOSS_W-1:0]  loss_cnt_o
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               pll_reset_q, sys_rst_n_q, locked_q, fail_q;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_LIMIT) begin
            state_d = FAILED;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = RESET_PLL;
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
      FAILED: begin
        cnt_d = '0;
        if (restart) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are flopped from the next state so they track state_q without decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == RESET_PLL) || (state_d == FAILED);
      sys_rst_n_q <= (state_d == RUN);
      locked_q    <= (state_d == RUN);
      fail_q      <= (state_d == FAILED);
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short cycle parameters.
// Cycle n is the interval sampled by the n-th rising edge after rst_n deasserts.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int RST_C  = 4;
  localparam int TO_C   = 16;
  localparam int STAB_C = 8;
  localparam int MAXR   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               pll_lock = 1'b0;
  logic               restart = 1'b0;
  logic               pll_reset_o;
  logic               sys_rst_n_o;
  logic               locked_o;
  logic               fail_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  logic [LOSS_W-1:0]  loss_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (STAB_C),
    .MAX_RETRIES   (MAXR),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_reset_o(pll_reset_o),
    .sys_rst_n_o(sys_rst_n_o),
    .locked_o   (locked_o),
    .fail_o     (fail_o),
    .retry_cnt_o(retry_cnt_o),
    .loss_cnt_o (loss_cnt_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge; cyc is the upcoming rising edge.
  task automatic advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_bringup();
    pll_lock = 1'b0;
    restart  = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_locked(input int budget, input string tag);
    int k;
    k = 0;
    while (locked_o !== 1'b1 && k < budget) begin
      advance();
      k++;
    end
    n_checks++;
    if (locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: locked_o=%b after %0d cycles, required 1", tag, locked_o, budget);
    end
  endtask

  task automatic test_reset();
    pll_lock = 1'b1;
    restart  = 1'b1;
    rst_n    = 1'b0;
    advance();
    advance();
    n_checks++;
    if ({pll_reset_o, sys_rst_n_o, locked_o, fail_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b%b required 1000", pll_reset_o, sys_rst_n_o,
               locked_o, fail_o);
    end
    n_checks++;
    if (retry_cnt_o !== 4'd0 || loss_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts: retry=%0d loss=%0d required 0/0", retry_cnt_o, loss_cnt_o);
    end
    restart = 1'b0;
  endtask

  task automatic test_nominal();
    start_bringup();
    for (int n = 0; n <= 20; n++) begin
      pll_lock = (n >= 4);
      n_checks++;
      if (pll_reset_o !== (n <= 3) || sys_rst_n_o !== (n >= 15) || locked_o !== (n >= 15)) begin
        n_fail++;
        $display("FAIL nominal cyc=%0d: rst=%b sys=%b lck=%b required %b %b %b", n, pll_reset_o,
                 sys_rst_n_o, locked_o, (n <= 3), (n >= 15), (n >= 15));
      end
      advance();
    end
  endtask

  task automatic test_glitch();
    // Low sample at edge 9 aborts STABILIZE at cycle 11; re-entry at 13 releases at 21.
    start_bringup();
    for (int n = 0; n <= 26; n++) begin
      pll_lock = (n >= 4) && (n != 9);
      n_checks++;
      if (sys_rst_n_o !== (n >= 21)) begin
        n_fail++;
        $display("FAIL glitch cyc=%0d: sys_rst_n_o=%b required %b", n, sys_rst_n_o, (n >= 21));
      end
      advance();
    end
  endtask

  task automatic test_glitch_last();
    // Low sample at edge 12 lands on the last STABILIZE cycle (14): no release until 24.
    start_bringup();
    for (int n = 0; n <= 26; n++) begin
      pll_lock = (n >= 4) && (n != 12);
      n_checks++;
      if (sys_rst_n_o !== (n >= 24)) begin
        n_fail++;
        $display("FAIL glitch_last cyc=%0d: sys_rst_n_o=%b required %b", n, sys_rst_n_o,
                 (n >= 24));
      end
      advance();
    end
  endtask

  task automatic test_lock_at_timeout();
    // lock_s first rises in cycle 19, the final WAIT_LOCK cycle: lock must win.
    start_bringup();
    for (int n = 0; n <= 30; n++) begin
      pll_lock = (n >= 17);
      n_checks++;
      if (retry_cnt_o !== 4'd0 || pll_reset_o !== (n <= 3) || sys_rst_n_o !== (n >= 28)) begin
        n_fail++;
        $display("FAIL lock_at_timeout cyc=%0d: retry=%0d rst=%b sys=%b required 0 %b %b", n,
                 retry_cnt_o, pll_reset_o, sys_rst_n_o, (n <= 3), (n >= 28));
      end
      advance();
    end
  endtask

  task automatic test_timeout_fail();
    logic [3:0] exp_retry;
    logic       exp_rst;
    logic       exp_fail;
    start_bringup();
    for (int n = 0; n <= 70; n++) begin
      // Pulses at 10 (WAIT_LOCK) are ignored; the one at 63 (FAILED) restarts.
      restart = (n == 10) || (n == 63);
      if (n <= 63) begin
        exp_retry = (n >= 40) ? 4'd2 : (n >= 20) ? 4'd1 : 4'd0;
        exp_rst   = (n <= 3) || (n >= 20 && n <= 23) || (n >= 40 && n <= 43) || (n >= 60);
        exp_fail  = (n >= 60);
      end else begin
        exp_retry = 4'd0;
        exp_rst   = (n <= 67);
        exp_fail  = 1'b0;
      end
      n_checks++;
      if (retry_cnt_o !== exp_retry || pll_reset_o !== exp_rst || fail_o !== exp_fail ||
          sys_rst_n_o !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout cyc=%0d: retry=%0d rst=%b fail=%b sys=%b required %0d %b %b 0", n,
                 retry_cnt_o, pll_reset_o, fail_o, sys_rst_n_o, exp_retry, exp_rst, exp_fail);
      end
      advance();
    end
    restart = 1'b0;
  endtask

  task automatic test_runtime_loss();
    logic exp_sys;
    logic exp_rst;
    start_bringup();
    for (int n = 0; n <= 40; n++) begin
      pll_lock = (n >= 4) && !(n >= 20 && n <= 22);
      exp_sys  = (n >= 15 && n <= 22) || (n >= 36);
      exp_rst  = (n <= 3) || (n >= 23 && n <= 26);
      n_checks++;
      if (sys_rst_n_o !== exp_sys || pll_reset_o !== exp_rst || locked_o !== exp_sys ||
          loss_cnt_o !== ((n >= 23) ? 8'd1 : 8'd0) || retry_cnt_o !== 4'd0) begin
        n_fail++;
        $display("FAIL loss cyc=%0d: sys=%b rst=%b lck=%b loss=%0d retry=%0d required %b %b %b %0d 0",
                 n, sys_rst_n_o, pll_reset_o, locked_o, loss_cnt_o, retry_cnt_o, exp_sys, exp_rst,
                 exp_sys, (n >= 23) ? 1 : 0);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_loss;
    start_bringup();
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b1;
      wait_locked(60, "sat_relock");
      pll_lock = 1'b0;
      advance();
      pll_lock = 1'b1;
      advance();
      advance();
      exp_loss = (i + 1 >= 255) ? 8'd255 : 8'(i + 1);
      n_checks++;
      if (loss_cnt_o !== exp_loss || sys_rst_n_o !== 1'b0) begin
        n_fail++;
        $display("FAIL saturation loss #%0d: loss=%0d sys=%b required %0d 0", i + 1, loss_cnt_o,
                 sys_rst_n_o, exp_loss);
      end
    end
    wait_locked(60, "sat_final_lock");
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (locked_o !== 1'b1 || loss_cnt_o !== 8'd255) begin
      n_fail++;
      $display("FAIL async_pre: lck=%b loss=%0d required 1 255", locked_o, loss_cnt_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sys_rst_n_o !== 1'b0 || pll_reset_o !== 1'b1 || locked_o !== 1'b0 ||
        loss_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: sys=%b rst=%b lck=%b loss=%0d required 0 1 0 0", sys_rst_n_o,
               pll_reset_o, locked_o, loss_cnt_o);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_glitch_last();
    test_lock_at_timeout();
    test_timeout_fail();
    test_runtime_loss();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
